// File: rtl/irq_priority_isr_if.sv
// Bus-side signal bundle of the interrupt priority / in-service stage.
//   inta     : active-low acknowledge from the CPU (synchronous to clk)
//   intr     : interrupt request to the CPU
//   data_out : vector or poll byte
//   data_oe  : drive enable for data_out
// With IRQ_POLL_EN defined the bundle also carries:
//   poll_stb : one-cycle OCW3 poll strobe
//   rd_n     : active-low read strobe used to return the poll byte
// master = CPU / bus-interface side, slave = the priority stage.
interface irq_priority_isr_if;
   logic       inta;
   logic       intr;
   logic [7:0] data_out;
   logic       data_oe;
`ifdef IRQ_POLL_EN
   logic       poll_stb;
   logic       rd_n;

   modport master (output inta, output poll_stb, output rd_n,
                   input intr, input data_out, input data_oe);
   modport slave  (input inta, input poll_stb, input rd_n,
                   output intr, output data_out, output data_oe);
`else
   modport master (output inta, input intr, input data_out, input data_oe);
   modport slave  (input inta, output intr, output data_out, output data_oe);
`endif
endinterface

// File: rtl/irq_priority_isr.sv
// Priority resolution and in-service stage of the interrupt controller.
// Latches raw requests into IRR, resolves the highest-priority unmasked
// request against ISR (fully nested, rotating priority), raises intr, runs
// the two-pulse INTA sequence, returns the vector and applies EOI commands.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   ir_req[7:0]       : raw request lines (synchronous to clk)
//   ltim              : 1 = level-triggered, 0 = rising-edge-triggered
//   imr[7:0]          : request mask, 1 = masked
//   v_a[4:0]          : vector base T7..T3
//   aeoi              : automatic EOI at the end of the acknowledge
//   eoi_stb           : OCW2 fields valid this cycle
//   non_specific_eoi, specific_eoi, rotate, l123[2:0] : OCW2 decodes
//   irr[7:0], isr[7:0]: request and in-service registers
//   bus               : intr / inta / data_out / data_oe bundle (slave)
//
// Optional feature: define IRQ_POLL_EN to add poll_stb / rd_n poll support.
//
// state | meaning
// IDLE  | waiting for the first INTA fall; intr may be asserted
// ACK1  | first INTA pulse in progress (bus not driven)
// ACK2  | second INTA pulse; vector driven while inta is low
module irq_priority_isr #(
   parameter int NUM_IR   = 8,
   parameter int RESET_LP = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_IR-1:0] ir_req,
   input  logic              ltim,
   input  logic [NUM_IR-1:0] imr,
   input  logic [4:0]        v_a,
   input  logic              aeoi,
   input  logic              eoi_stb,
   input  logic              non_specific_eoi,
   input  logic              specific_eoi,
   input  logic              rotate,
   input  logic [2:0]        l123,
   output logic [NUM_IR-1:0] irr,
   output logic [NUM_IR-1:0] isr,
   irq_priority_isr_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_IR);

   typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

   state_t            state_q, state_n;
   logic [NUM_IR-1:0] ir_q, irr_n, isr_n, set_mask, clr_mask;
   logic [IDX_W-1:0]  lp_q, lp_n, idx_q, idx_n;
   logic              spur_q, spur_n, int_q, int_n, inta_q;
   logic              fall, rise, grant, ack_oe;
   logic              w_valid, s_valid;
   logic [IDX_W-1:0]  w_idx, s_idx, rank_w, rank_s;

   // Scan from lowest rank to highest so the last hit is the winner.
   function automatic logic [IDX_W:0] pick_top(input logic [NUM_IR-1:0] vec,
                                               input logic [IDX_W-1:0]  lp);
      logic [IDX_W-1:0] pos;
      pick_top = '0;
      for (int k = NUM_IR - 1; k >= 0; k--) begin
         pos = lp + IDX_W'(k + 1);
         if (vec[pos]) pick_top = {1'b1, pos};
      end
   endfunction

   assign {w_valid, w_idx} = pick_top(irr & ~imr, lp_q);
   assign {s_valid, s_idx} = pick_top(isr, lp_q);
   assign rank_w = w_idx - lp_q - IDX_W'(1);
   assign rank_s = s_idx - lp_q - IDX_W'(1);

   assign fall = inta_q & ~bus.inta;
   assign rise = ~inta_q & bus.inta;

`ifdef IRQ_POLL_EN
   logic       rd_q, rd_rise, poll_hold_q, poll_hold_n, poll_oe;
   logic [7:0] poll_byte_q, poll_byte_n;
   assign rd_rise = ~rd_q & bus.rd_n;
`endif

   always_comb begin
      state_n  = state_q;
      idx_n    = idx_q;
      spur_n   = spur_q;
      lp_n     = lp_q;
      set_mask = '0;
      clr_mask = '0;
      grant    = 1'b0;
      int_n    = (state_q == IDLE) && w_valid && (!s_valid || (rank_w < rank_s));

      case (state_q)
         IDLE: begin
            if (fall) begin
               grant   = w_valid;
               idx_n   = w_valid ? w_idx : '1;
               spur_n  = ~w_valid;
               int_n   = 1'b0;
               state_n = ACK1;
            end
         end
         ACK1: begin
            if (rise) state_n = ACK2;
         end
         ACK2: begin
            if (rise) begin
               state_n = IDLE;
               if (aeoi && !spur_q) begin
                  clr_mask[idx_q] = 1'b1;
                  if (rotate) lp_n = idx_q;
               end
            end
         end
         default: state_n = IDLE;
      endcase

`ifdef IRQ_POLL_EN
      poll_byte_n = poll_byte_q;
      poll_hold_n = poll_hold_q;
      if (poll_hold_q && rd_rise) poll_hold_n = 1'b0;
      // A poll acts like an ACK1 grant; it is only taken while no INTA
      // sequence is starting or running.
      if (bus.poll_stb && (state_q == IDLE) && !fall) begin
         grant       = w_valid;
         poll_byte_n = {w_valid, 4'b0000, w_idx};
         poll_hold_n = 1'b1;
      end
      if (bus.poll_stb || poll_hold_q) int_n = 1'b0;
`endif

      if (grant) set_mask[w_idx] = 1'b1;

      // EOI target comes from the pre-update ISR; a same-cycle grant
      // set of the same bit wins because set is applied after clear.
      if (eoi_stb) begin
         if (non_specific_eoi) begin
            if (s_valid) begin
               clr_mask[s_idx] = 1'b1;
               if (rotate) lp_n = s_idx;
            end
         end else if (specific_eoi) begin
            clr_mask[l123] = 1'b1;
            if (rotate) lp_n = l123;
         end
      end

      isr_n = (isr & ~clr_mask) | set_mask;
      irr_n = ((ltim ? ir_req : (ir_req & ~ir_q)) | (irr & ir_req)) & ~set_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         irr     <= '0;
         isr     <= '0;
         lp_q    <= IDX_W'(RESET_LP);
         idx_q   <= '0;
         spur_q  <= 1'b0;
         int_q   <= 1'b0;
         ir_q    <= '0;
         inta_q  <= 1'b1;
      end else begin
         state_q <= state_n;
         irr     <= irr_n;
         isr     <= isr_n;
         lp_q    <= lp_n;
         idx_q   <= idx_n;
         spur_q  <= spur_n;
         int_q   <= int_n;
         ir_q    <= ir_req;
         inta_q  <= bus.inta;
      end
   end

   assign ack_oe   = (state_q == ACK2) && !bus.inta;
   assign bus.intr = int_q;

`ifdef IRQ_POLL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q        <= 1'b1;
         poll_hold_q <= 1'b0;
         poll_byte_q <= '0;
      end else begin
         rd_q        <= bus.rd_n;
         poll_hold_q <= poll_hold_n;
         poll_byte_q <= poll_byte_n;
      end
   end

   assign poll_oe      = poll_hold_q && !bus.rd_n;
   assign bus.data_oe  = ack_oe | poll_oe;
   assign bus.data_out = ack_oe ? {v_a, idx_q} : (poll_oe ? poll_byte_q : 8'h00);
`else
   assign bus.data_oe  = ack_oe;
   assign bus.data_out = ack_oe ? {v_a, idx_q} : 8'h00;
`endif

endmodule

// File: tb/tb_irq_priority_isr.sv
module tb_irq_priority_isr;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ir_req, imr;
   logic       ltim, aeoi, eoi_stb, nse, se, rotate, inta;
   logic [4:0] v_a;
   logic [2:0] l123;
   logic [7:0] irr, isr;
   int         checks, errors;

   irq_priority_isr_if bus();
   assign bus.inta = inta;
`ifdef IRQ_POLL_EN
   assign bus.poll_stb = 1'b0;
   assign bus.rd_n     = 1'b1;
`endif

   irq_priority_isr dut (
      .clk(clk), .rst_n(rst_n), .ir_req(ir_req), .ltim(ltim), .imr(imr),
      .v_a(v_a), .aeoi(aeoi), .eoi_stb(eoi_stb), .non_specific_eoi(nse),
      .specific_eoi(se), .rotate(rotate), .l123(l123),
      .irr(irr), .isr(isr), .bus(bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [7:0] irr;
      logic [7:0] isr;
      logic [7:0] ir_q;
      int         lp;
      int         phase;   // 0 idle, 1 first pulse, 2 second pulse
      int         idx;
      bit         spur;
      bit         intr;
      bit         inta_q;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.irr = '0; r.isr = '0; r.ir_q = '0; r.lp = 7; r.phase = 0; r.idx = 0;
      r.spur = 1'b0; r.intr = 1'b0; r.inta_q = 1'b1;
      return r;
   endfunction

   function automatic int top_of(logic [7:0] v, int lp);
      for (int k = 0; k < 8; k++)
         if (v[(lp + 1 + k) % 8]) return (lp + 1 + k) % 8;
      return -1;
   endfunction

   function automatic int rank_of(int i, int lp);
      return (i - lp - 1 + 16) % 8;
   endfunction

   function automatic model_t model_next(model_t c);
      model_t     n;
      int         w, s, gnt;
      bit         fall, rise;
      logic [7:0] clr;
      n    = c;
      w    = top_of(c.irr & ~imr, c.lp);
      s    = top_of(c.isr, c.lp);
      fall = c.inta_q && !inta;
      rise = !c.inta_q && inta;
      clr  = '0;
      gnt  = -1;
      for (int i = 0; i < 8; i++) begin
         if (ltim ? ir_req[i] : (ir_req[i] && !c.ir_q[i])) n.irr[i] = 1'b1;
         else if (!ir_req[i]) n.irr[i] = 1'b0;
      end
      n.intr = (c.phase == 0) && (w >= 0) && (s < 0 || rank_of(w, c.lp) < rank_of(s, c.lp));
      if (c.phase == 0 && fall) begin
         n.intr = 1'b0; n.phase = 1; n.spur = (w < 0); n.idx = (w < 0) ? 7 : w; gnt = w;
      end else if (c.phase == 1 && rise) begin
         n.phase = 2;
      end else if (c.phase == 2 && rise) begin
         n.phase = 0;
         if (aeoi && !c.spur) begin
            clr[c.idx] = 1'b1;
            if (rotate) n.lp = c.idx;
         end
      end
      if (eoi_stb) begin
         if (nse) begin
            if (s >= 0) begin
               clr[s] = 1'b1;
               if (rotate) n.lp = s;
            end
         end else if (se) begin
            clr[l123] = 1'b1;
            if (rotate) n.lp = int'(l123);
         end
      end
      n.isr = c.isr & ~clr;
      if (gnt >= 0) begin
         n.isr[gnt] = 1'b1;
         n.irr[gnt] = 1'b0;
      end
      n.ir_q   = ir_req;
      n.inta_q = inta;
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_next(m);
   end

   function automatic logic [25:0] exp_bus();
      logic       oe;
      logic [7:0] d;
      oe = (m.phase == 2) && !inta;
      d  = oe ? {v_a, 3'(m.idx)} : 8'h00;
      return {m.irr, m.isr, m.intr, oe, d};
   endfunction

   function automatic logic [25:0] obs_bus();
      return {irr, isr, bus.intr, bus.data_oe, bus.data_out};
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic ack_seq(output logic p1_oe, output logic p2_oe,
                          output logic [7:0] vec, output logic [7:0] vec_exp);
      logic [25:0] e;
      p1_oe = 1'b0;
      inta = 1'b0; tick(); p1_oe |= bus.data_oe; tick(); p1_oe |= bus.data_oe;
      inta = 1'b1; tick(); tick();
      inta = 1'b0; tick(); tick();
      p2_oe = bus.data_oe; vec = bus.data_out; e = exp_bus(); vec_exp = e[7:0];
      inta = 1'b1; tick(); tick();
   endtask

   task automatic eoi_cmd(input logic n_s, input logic s_s, input logic rot, input logic [2:0] lvl);
      eoi_stb = 1'b1; nse = n_s; se = s_s; rotate = rot; l123 = lvl;
      tick();
      eoi_stb = 1'b0; nse = 1'b0; se = 1'b0; rotate = 1'b0;
      tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      tick(); tick();
      checks++;
      if (obs_bus() !== 26'h0) begin
         errors++; $display("FAIL reset_hold: got %h want %h", obs_bus(), 26'h0);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (obs_bus() !== exp_bus()) begin
         errors++; $display("FAIL reset_release: got %h want %h", obs_bus(), exp_bus());
      end
   endtask

   task automatic test_basic();
      logic p1, p2; logic [7:0] vec, ve;
      ltim = 1'b0; imr = 8'h00; v_a = 5'b01000;
      ir_req = 8'h08; tick();
      checks++;
      if (irr !== 8'h08) begin errors++; $display("FAIL basic_irr: got %h want 08", irr); end
      tick();
      checks++;
      if (bus.intr !== 1'b1) begin errors++; $display("FAIL basic_int: got %b want 1", bus.intr); end
      ack_seq(p1, p2, vec, ve);
      checks++;
      if ({p1, p2} !== 2'b01) begin errors++; $display("FAIL basic_oe_pulses: got %b want 01", {p1, p2}); end
      checks++;
      if (vec !== 8'h43 || ve !== 8'h43) begin
         errors++; $display("FAIL basic_vector: got %h model %h want 43", vec, ve);
      end
      checks++;
      if ({isr, irr, bus.data_oe} !== {8'h08, 8'h00, 1'b0}) begin
         errors++; $display("FAIL basic_after: got isr %h irr %h oe %b want 08 00 0", isr, irr, bus.data_oe);
      end
      ir_req = 8'h00; tick();
   endtask

   task automatic test_nested();
      logic p1, p2; logic [7:0] vec, ve;
      ir_req = 8'h20; tick(); tick(); tick();
      checks++;
      if ({irr, bus.intr} !== {8'h20, 1'b0}) begin
         errors++; $display("FAIL nested_lower_blocked: got irr %h int %b want 20 0", irr, bus.intr);
      end
      ir_req = 8'h22; tick(); tick();
      checks++;
      if (bus.intr !== 1'b1) begin errors++; $display("FAIL nested_higher_int: got %b want 1", bus.intr); end
      ack_seq(p1, p2, vec, ve);
      checks++;
      if ({vec, isr, irr} !== {8'h41, 8'h0A, 8'h20}) begin
         errors++; $display("FAIL nested_ack: got vec %h isr %h irr %h want 41 0a 20", vec, isr, irr);
      end
   endtask

   task automatic test_eoi();
      eoi_cmd(1'b1, 1'b0, 1'b0, 3'd0);
      checks++;
      if (isr !== 8'h08) begin errors++; $display("FAIL eoi_nonspecific: got %h want 08", isr); end
      eoi_cmd(1'b0, 1'b1, 1'b0, 3'd3);
      checks++;
      if (isr !== 8'h00) begin errors++; $display("FAIL eoi_specific: got %h want 00", isr); end
      ir_req = 8'h00; tick(); tick(); tick();
      checks++;
      if (obs_bus() !== exp_bus() || irr !== 8'h00 || bus.intr !== 1'b0) begin
         errors++; $display("FAIL eoi_quiesce: got %h want %h", obs_bus(), exp_bus());
      end
   endtask

   task automatic test_rotation();
      logic p1, p2; logic [7:0] vec, ve;
      ir_req = 8'h10; tick(); tick();
      ack_seq(p1, p2, vec, ve);
      ir_req = 8'h00; tick();
      checks++;
      if ({vec, isr} !== {8'h44, 8'h10}) begin
         errors++; $display("FAIL rot_setup: got vec %h isr %h want 44 10", vec, isr);
      end
      eoi_cmd(1'b1, 1'b0, 1'b1, 3'd0);
      ir_req = 8'h30; tick(); tick();
      ack_seq(p1, p2, vec, ve);
      checks++;
      if ({vec, ve, isr, irr} !== {8'h45, 8'h45, 8'h20, 8'h10}) begin
         errors++; $display("FAIL rot_order: got vec %h model %h isr %h irr %h want 45 45 20 10", vec, ve, isr, irr);
      end
      eoi_cmd(1'b0, 1'b1, 1'b0, 3'd5);
      ir_req = 8'h00; tick(); tick(); tick();
      checks++;
      if (obs_bus() !== exp_bus() || isr !== 8'h00) begin
         errors++; $display("FAIL rot_cleanup: got %h want %h", obs_bus(), exp_bus());
      end
   endtask

   task automatic test_spurious();
      logic p1, p2; logic [7:0] vec, ve;
      ltim = 1'b1;
      ir_req = 8'h04; tick(); tick();
      ir_req = 8'h00; tick();
      ack_seq(p1, p2, vec, ve);
      checks++;
      if ({vec, ve, isr, p2} !== {8'h47, 8'h47, 8'h00, 1'b1}) begin
         errors++; $display("FAIL spurious: got vec %h model %h isr %h oe %b want 47 47 00 1", vec, ve, isr, p2);
      end
      ltim = 1'b0; tick();
   endtask

   task automatic test_aeoi_reset();
      aeoi = 1'b1;
      ir_req = 8'h40; tick(); tick();
      inta = 1'b0; tick(); tick();
      checks++;
      if (isr !== 8'h40) begin errors++; $display("FAIL aeoi_mid: got %h want 40", isr); end
      inta = 1'b1; tick(); tick();
      inta = 1'b0; tick(); tick();
      checks++;
      if ({bus.data_oe, bus.data_out} !== {1'b1, 8'h46}) begin
         errors++; $display("FAIL aeoi_vector: got oe %b data %h want 1 46", bus.data_oe, bus.data_out);
      end
      inta = 1'b1; tick(); tick();
      checks++;
      if (isr !== 8'h00) begin errors++; $display("FAIL aeoi_clear: got %h want 00", isr); end
      ir_req = 8'h00; tick();
      ir_req = 8'h40; tick(); tick();
      inta = 1'b0; tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs_bus() !== 26'h0) begin
         errors++; $display("FAIL reset_mid_ack: got %h want %h", obs_bus(), 26'h0);
      end
      tick();
      inta = 1'b1; ir_req = 8'h00; aeoi = 1'b0;
      tick();
      rst_n = 1'b1;
      tick(); tick();
      checks++;
      if (obs_bus() !== exp_bus()) begin
         errors++; $display("FAIL reset_recover: got %h want %h", obs_bus(), exp_bus());
      end
   endtask

   task automatic test_random();
      logic [7:0] pat;
      int         ack_pos;
      int         cyc;
      pat = 8'b1100_1100;
      ack_pos = 0;
      cyc = 0;
      while (cyc < 600 || ack_pos != 0) begin
         checks++;
         if (obs_bus() !== exp_bus()) begin
            errors++; $display("FAIL random_cycle_%0d: got %h want %h", cyc, obs_bus(), exp_bus());
         end
         if (cyc % 75 == 0) begin
            ltim = 1'($urandom_range(0, 1));
            aeoi = 1'($urandom_range(0, 1));
         end
         if (cyc < 600) begin
            if ($urandom_range(0, 3) == 0)  ir_req = 8'($urandom);
            if ($urandom_range(0, 15) == 0) imr = 8'($urandom);
            eoi_stb = ($urandom_range(0, 9) == 0);
            nse     = 1'($urandom_range(0, 1));
            se      = ~nse;
            rotate  = 1'($urandom_range(0, 1));
            l123    = 3'($urandom_range(0, 7));
            if (ack_pos == 0 && $urandom_range(0, 5) == 0) ack_pos = 1;
         end else begin
            eoi_stb = 1'b0;
         end
         if (ack_pos != 0) begin
            inta = pat[ack_pos - 1];
            ack_pos = (ack_pos == 8) ? 0 : ack_pos + 1;
         end else begin
            inta = 1'b1;
         end
         tick();
         cyc++;
      end
      eoi_stb = 1'b0; nse = 1'b0; se = 1'b0; rotate = 1'b0; inta = 1'b1;
      tick();
      checks++;
      if (obs_bus() !== exp_bus()) begin
         errors++; $display("FAIL random_final: got %h want %h", obs_bus(), exp_bus());
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      ir_req = 8'h00; imr = 8'h00; ltim = 1'b0; aeoi = 1'b0; v_a = 5'b01000;
      eoi_stb = 1'b0; nse = 1'b0; se = 1'b0; rotate = 1'b0; l123 = 3'd0; inta = 1'b1;
      rst_n = 1'b0;
      test_reset();
      test_basic();
      test_nested();
      test_eoi();
      test_rotation();
      test_spurious();
      test_aeoi_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
